// File: rtl/sync_toggle_event_rx.sv
// Receive side of a toggle-based event crossing: filters the synchronized level,
// emits one pulse per accepted toggle and queues events in a saturating pending counter.
module sync_toggle_event_rx #(
    parameter int unsigned FILT_CYC = 2,
    parameter int unsigned CNT_W    = 4,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic             o_clk,
    input  logic             o_rst,
    input  logic             sync_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             lvl_o,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_pending,
    output logic             evt_ovf
);

    localparam logic [3:0]       FiltLast = 4'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic             lvl_q, lvl_d;
    logic [3:0]       stab_q, stab_d;
    logic             pulse_q;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             dec;

    always_comb begin
        lvl_d  = lvl_q;
        stab_d = stab_q;
        accept = 1'b0;
        if (sync_in == lvl_q) begin
            stab_d = 4'd0;
        end else if (stab_q >= FiltLast) begin
            lvl_d  = sync_in;
            stab_d = 4'd0;
            accept = 1'b1;
        end else begin
            stab_d = stab_q + 4'd1;
        end
    end

    // A simultaneous accept and drain cancel out and never count as an overflow.
    always_comb begin
        dec    = evt_ready && (pend_q != '0);
        pend_d = pend_q;
        ovf_d  = ovf_q & ~clr_ovf;
        if (accept && !dec) begin
            if (pend_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + CntOne;
            end
        end else if (!accept && dec) begin
            pend_d = pend_q - CntOne;
        end
    end

    always_ff @(posedge o_clk or posedge o_rst) begin
        if (o_rst) begin
            lvl_q   <= RST_VAL;
            stab_q  <= 4'd0;
            pulse_q <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            stab_q  <= stab_d;
            pulse_q <= accept;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign lvl_o       = lvl_q;
    assign evt_pulse   = pulse_q;
    assign evt_pending = pend_q;
    assign evt_valid   = (pend_q != '0);
    assign evt_ovf     = ovf_q;

endmodule
